// File: rtl/tiny_dnn_pkg.sv
// Shared constants and state encoding for the tiny_dnn sequencer.
package tiny_dnn_pkg;

  // Weight words per bank; the top address of each bank holds the bias.
  localparam int unsigned F_SIZE = 1024;
  localparam int unsigned AW     = $clog2(F_SIZE);

  localparam logic [AW-1:0] BIAS_ADDR = AW'(F_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_EXEC,
    S_BIAS,
    S_WAIT,
    S_DRAIN,
    S_FIN
  } seq_state_t;

endpackage

// File: rtl/tiny_dnn_seq.sv
// Pass sequencer for a chain of tiny_dnn_core instances: init, exec over the
// weight row, optional bias, pipeline drain wait, then shift-out of all
// accumulators through the chain tail under out_valid/out_ready handshake.
module tiny_dnn_seq
  import tiny_dnn_pkg::*;
#(
  parameter int unsigned N_CORE  = 16,
  parameter int unsigned FMA_LAT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] in_len,
  input  logic          bank,
  input  logic          use_bias,
  output logic          busy,
  output logic          done,
  output logic          init,
  output logic          exec,
  output logic          bias,
  output logic          update,
  output logic          outr,
  output logic [AW:0]   ra,
  output logic          src_rd,
  output logic [AW-1:0] src_addr,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int unsigned JW = (N_CORE  > 1) ? $clog2(N_CORE)  : 1;
  localparam int unsigned WW = (FMA_LAT > 1) ? $clog2(FMA_LAT) : 1;

  seq_state_t    state_q;
  logic [AW-1:0] len_q;
  logic          bank_q;
  logic          bias_en_q;
  logic [AW-1:0] k_q;
  logic [WW-1:0] w_q;
  logic [JW-1:0] j_q;

  // Pass control: state transitions, latched pass parameters and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      bank_q    <= 1'b0;
      bias_en_q <= 1'b0;
      k_q       <= '0;
      w_q       <= '0;
      j_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q     <= in_len;
            bank_q    <= bank;
            bias_en_q <= use_bias;
            state_q   <= S_INIT;
          end
        end
        S_INIT: begin
          k_q <= '0;
          w_q <= '0;
          if (len_q != '0) begin
            state_q <= S_EXEC;
          end else if (bias_en_q) begin
            state_q <= S_BIAS;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_EXEC: begin
          if (k_q == len_q - AW'(1)) begin
            if (bias_en_q) begin
              state_q <= S_BIAS;
            end else begin
              state_q <= S_WAIT;
            end
          end else begin
            k_q <= k_q + AW'(1);
          end
        end
        S_BIAS: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (w_q == WW'(FMA_LAT - 1)) begin
            j_q     <= '0;
            state_q <= S_DRAIN;
          end else begin
            w_q <= w_q + WW'(1);
          end
        end
        S_DRAIN: begin
          // j only moves on an accepted result; a stall freezes everything.
          if (out_ready) begin
            if (j_q == JW'(N_CORE - 1)) begin
              state_q <= S_FIN;
            end else begin
              j_q <= j_q + JW'(1);
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Core strobes, addresses and handshake outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    init      = 1'b0;
    exec      = 1'b0;
    bias      = 1'b0;
    update    = 1'b0;
    outr      = 1'b0;
    ra        = '0;
    src_rd    = 1'b0;
    src_addr  = '0;
    out_valid = 1'b0;
    unique case (state_q)
      S_INIT: init = 1'b1;
      S_EXEC: begin
        exec     = 1'b1;
        ra       = {bank_q, k_q};
        src_rd   = 1'b1;
        src_addr = k_q;
      end
      S_BIAS: begin
        bias = 1'b1;
        ra   = {bank_q, BIAS_ADDR};
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        outr      = out_ready;
        // update stays high through stalls at j=0; without outr it has no effect.
        update    = (j_q == '0);
      end
      S_FIN: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Self-checking bench for tiny_dnn_seq: a behavioural core-chain model driven
// by the DUT strobes produces the tail value; expected dot products are
// computed directly from weights and activations and queued per pass.
module tb_tiny_dnn_seq;
  import tiny_dnn_pkg::*;

  localparam int NC = 16;
  localparam int FL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  in_len = '0;
  logic        bank = 1'b0;
  logic        use_bias = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, done, init, exec, bias, update, outr, src_rd, out_valid;
  logic [10:0] ra;
  logic [9:0]  src_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  tiny_dnn_seq #(.N_CORE(NC), .FMA_LAT(FL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_len(in_len), .bank(bank),
    .use_bias(use_bias), .busy(busy), .done(done), .init(init), .exec(exec),
    .bias(bias), .update(update), .outr(outr), .ra(ra), .src_rd(src_rd),
    .src_addr(src_addr), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- data and reference ----------------
  int d_mem [1024];
  bit ones_mode = 0;
  int exp_q [$];

  function automatic int wgt(input int core, input int addr);
    if (ones_mode) return 1;
    return ((core * 37 + addr * 11 + (addr >> 4)) % 97) + 1;
  endfunction

  function automatic int dot(input int core, input int len, input bit bnk, input bit ub);
    int s;
    s = 0;
    for (int k = 0; k < len; k++) s += wgt(core, bnk * 1024 + k) * d_mem[k];
    if (ub) s += wgt(core, bnk * 1024 + 1023);
    return s;
  endfunction

  // ---------------- core chain model ----------------
  int acc [NC];
  int sr [NC];
  logic m_init = 0, m_exec = 0, m_bias = 0, m_update = 0, m_outr = 0, m_rd = 0;
  logic [10:0] m_ra = '0;
  logic [9:0]  m_sa = '0;

  always @(negedge clk) begin
    m_init <= init; m_exec <= exec; m_bias <= bias; m_update <= update;
    m_outr <= outr; m_rd <= src_rd; m_ra <= ra; m_sa <= src_addr;
  end

  always @(posedge clk) begin
    if (m_init) for (int i = 0; i < NC; i++) acc[i] = 0;
    if (m_exec && m_rd) for (int i = 0; i < NC; i++) acc[i] += wgt(i, int'(m_ra)) * d_mem[int'(m_sa)];
    if (m_bias) for (int i = 0; i < NC; i++) acc[i] += wgt(i, int'(m_ra));
    if (m_outr) begin
      for (int i = NC - 1; i > 0; i--) sr[i] = m_update ? acc[i-1] : sr[i-1];
      sr[0] = 0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  int mon_tail, mon_exp, mon_idx = 0;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_tail = update ? acc[NC-1] : sr[NC-1];
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_extra got %0d expected none", mon_tail);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_tail != mon_exp) begin
          errors++;
          $display("FAIL result[%0d] got %0d expected %0d", mon_idx, mon_tail, mon_exp);
        end
      end
      mon_idx++;
    end
  end

  // ---------------- per-pass protocol observer ----------------
  int p_t0, p_first_v, p_done_c, p_exec, p_bias, p_init, p_done, p_stall, p_bad, p_starts, p_busy;
  bit p_acc_seen, done_seen;
  logic p_bank = 1'b0;
  int vcnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (start && !busy) begin p_t0 = cyc; p_starts++; end
      if (busy) p_busy++;
      if (init) p_init++;
      if (exec) begin
        if (ra !== {p_bank, 10'(p_exec)} || src_rd !== 1'b1 || src_addr !== 10'(p_exec)) p_bad++;
        p_exec++;
      end else if (src_rd) p_bad++;
      if (bias) begin
        p_bias++;
        if (ra !== {p_bank, 10'h3FF}) p_bad++;
      end
      if (exec && bias) p_bad++;
      if (out_valid) begin
        vcnt++;
        if (p_first_v < 0) p_first_v = cyc;
        if (update !== !p_acc_seen) p_bad++;
        if (outr !== out_ready) p_bad++;
        if (!out_ready) p_stall++;
        else p_acc_seen = 1;
      end else if (outr || update) p_bad++;
      if (done) begin p_done++; p_done_c = cyc; done_seen = 1; end
    end
  end

  // ---------------- out_ready driver ----------------
  int rdy_mode = 0;
  logic [3:0] pat = 4'b1001;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = pat[vcnt % 4];
    endcase
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic clear_stats();
    p_t0 = 0; p_first_v = -1; p_done_c = 0; p_exec = 0; p_bias = 0; p_init = 0;
    p_done = 0; p_stall = 0; p_bad = 0; p_starts = 0; p_busy = 0;
    p_acc_seen = 0; done_seen = 0; vcnt = 0;
  endtask

  task automatic run_pass(input int len, input bit bnk, input bit ub, input int rmode, input bit poke);
    int n;
    @(posedge clk); #2;
    clear_stats();
    p_bank = bnk;
    rdy_mode = rmode;
    for (int i = NC - 1; i >= 0; i--) exp_q.push_back(dot(i, len, bnk, ub));
    in_len = 10'(len); bank = bnk; use_bias = ub; start = 1'b1;
    @(posedge clk); #2;
    if (!poke) start = 1'b0;
    // Pass parameters must be ignored once the pass is running.
    in_len = 10'($urandom); bank = 1'($urandom); use_bias = 1'($urandom);
    n = 0;
    while (!done_seen && n < 4000) begin
      if (poke) begin start = 1'b1; in_len = 10'($urandom); end
      @(posedge clk); #2;
      n++;
    end
    start = 1'b0;
    if (!done_seen) begin
      errors++;
      $display("FAIL done_timeout got no done expected done len=%0d", len);
      exp_q.delete();
      return;
    end
    chk("busy_after_fin", int'(busy), 0);
    chk("done_time", p_done_c - p_t0, 2 + len + int'(ub) + FL + NC + p_stall);
    chk("first_valid", p_first_v - p_t0, 2 + len + int'(ub) + FL);
    chk("exec_cnt", p_exec, len);
    chk("bias_cnt", p_bias, int'(ub));
    chk("init_cnt", p_init, 1);
    chk("done_cnt", p_done, 1);
    chk("strobe_err", p_bad, 0);
    chk("busy_cycles", p_busy, p_done_c - p_t0);
    @(posedge clk); #2;
    chk("starts", p_starts, 1);
    chk("queue_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reset_mid();
    @(posedge clk); #2;
    clear_stats();
    rdy_mode = 0;
    in_len = 10'd20; bank = 1'b1; use_bias = 1'b1; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #2; end
    chk("exec_before_rst", int'(exec), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", int'({busy, done, init, exec, bias, update, outr, src_rd, out_valid, ra, src_addr}), 0);
    repeat (2) begin @(posedge clk); #2; end
    chk("rst_hold_outs", int'({busy, done, init, exec, bias, update, outr, src_rd, out_valid, ra, src_addr}), 0);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    chk("idle_after_rst", int'(busy), 0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < 1024; k++) d_mem[k] = $urandom_range(0, 255);
    clear_stats();
    #3;
    chk("reset_outs", int'({busy, done, init, exec, bias, update, outr, src_rd, out_valid, ra, src_addr}), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    run_pass(4, 1'b0, 1'b1, 0, 1'b0);

    ones_mode = 1;
    for (int k = 0; k < 1024; k++) d_mem[k] = 1;
    run_pass(2, 1'b1, 1'b0, 0, 1'b0);
    ones_mode = 0;
    for (int k = 0; k < 1024; k++) d_mem[k] = $urandom_range(0, 255);

    run_pass(0, 1'b0, 1'b0, 0, 1'b0);
    run_pass(0, 1'b1, 1'b1, 0, 1'b0);
    run_pass(5, 1'b1, 1'b1, 2, 1'b0);
    run_pass(6, 1'b0, 1'b1, 0, 1'b1);

    reset_mid();
    run_pass(3, 1'b1, 1'b1, 0, 1'b0);

    repeat (12) begin
      run_pass($urandom_range(0, 40), 1'($urandom), 1'($urandom), 1, ($urandom_range(0, 3) == 0));
    end
    run_pass(1, 1'b1, 1'b0, 1, 1'b0);
    run_pass(1022, 1'b1, 1'b1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
